// File: rtl/hd_scoreboard.sv
// Self-checking scoreboard: queues expected words and compares each decoder output against the oldest one.
// Optional HD_SB_STOP_ON_FAIL_EN: the first mismatch sends the checker to its terminal ERROR state.
module hd_scoreboard #(
  parameter int k       = 8,
  parameter int DEPTH   = 16,
  parameter int MAX_LAT = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [k-1:0]             exp_din,
  input  logic                     exp_vld,
  input  logic [k-1:0]             act_din,
  input  logic                     act_vld,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   occ,
  output logic [15:0]              pass_cnt,
  output logic [15:0]              fail_cnt,
  output logic                     mismatch,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     timeout,
  output logic                     done
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(MAX_LAT + 1);
  localparam logic [PW-1:0] FULL_OCC = PW'(DEPTH);
  localparam logic [AW-1:0] LAT_LIM  = AW'(MAX_LAT);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, ERROR} state_t;

  state_t        state, state_nxt;
  logic [k-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, occ_nxt;
  logic [AW-1:0] age, age_nxt;
  logic          full, empty, push_ok, push, pop, head_eq, fail_ev;
  logic          of_set, uf_set, to_set, stop_fail, sticky_err, done_set;

  always_comb begin
    full       = (occ == FULL_OCC);
    empty      = (occ == '0);
    // Only IDLE/RUN accept expected words; a flush request wins over a push.
    push_ok    = exp_vld && !flush && ((state == IDLE) || (state == RUN));
    pop        = act_vld && !empty && (state != ERROR) && (state != DONE);
    push       = push_ok && (!full || pop);
    head_eq    = (act_din == mem[rd_ptr[PW-2:0]]);
    fail_ev    = pop && !head_eq;
    of_set     = push_ok && full && !pop;
    uf_set     = act_vld && empty && (state != ERROR);
    occ_nxt    = occ + PW'(push) - PW'(pop);
    sticky_err = overflow || underflow || timeout;
    if (empty || pop)        age_nxt = '0;
    else if (age != LAT_LIM) age_nxt = age + AW'(1);
    else                     age_nxt = age;
    to_set     = (age_nxt == LAT_LIM) && (state != ERROR);
  end

`ifdef HD_SB_STOP_ON_FAIL_EN
  assign stop_fail = fail_ev;
`else
  assign stop_fail = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    done_set  = 1'b0;
    case (state)
      IDLE: begin
        if (flush)     state_nxt = DRAIN;
        else if (push) state_nxt = RUN;
      end
      RUN: begin
        if (of_set || uf_set || to_set || stop_fail || sticky_err) state_nxt = ERROR;
        else if (flush)                                            state_nxt = DRAIN;
        else if (occ_nxt == '0)                                    state_nxt = IDLE;
      end
      DRAIN: begin
        if (uf_set || to_set || stop_fail || sticky_err) begin
          state_nxt = ERROR;
        end else if (empty) begin
          state_nxt = DONE;
          done_set  = 1'b1;
        end
      end
      DONE:    state_nxt = DONE;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = ERROR;
    endcase
  end

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-2:0]] <= exp_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      age       <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      mismatch  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      timeout   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state    <= state_nxt;
      occ      <= occ_nxt;
      age      <= age_nxt;
      mismatch <= fail_ev;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (pop && head_eq && (pass_cnt != 16'hFFFF)) pass_cnt <= pass_cnt + 16'd1;
      if (fail_ev && (fail_cnt != 16'hFFFF))        fail_cnt <= fail_cnt + 16'd1;
      if (of_set)   overflow  <= 1'b1;
      if (uf_set)   underflow <= 1'b1;
      if (to_set)   timeout   <= 1'b1;
      if (done_set) done      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hd_scoreboard.sv
// Bench for hd_scoreboard: two instances (MAX_LAT 16 and 3) share stimulus and are checked
// every cycle against a queue-based reference model, plus directed expectations.
module tb_hd_scoreboard;

  localparam int DEP = 4;
`ifdef HD_SB_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] exp_din = '0, act_din = '0;
  logic       exp_vld = 1'b0, act_vld = 1'b0, flush = 1'b0;

  logic [2:0]  occ [2];
  logic [15:0] pass_cnt [2], fail_cnt [2];
  logic        mismatch [2], overflow [2], underflow [2], timeout [2], done [2];

  int checks = 0;
  int failures = 0;

  // Reference model: expected words held as an ordered list, head at index 0.
  int         lat [2] = '{16, 3};
  logic [7:0] mq [2][DEP];
  int         mcnt [2], mage [2], m_pass [2], m_fail [2];
  bit         m_mis [2], m_of [2], m_uf [2], m_to [2], m_done [2], m_drain [2], m_err [2];

  always #5 clk = ~clk;

  hd_scoreboard #(.k(8), .DEPTH(DEP), .MAX_LAT(16)) u_sb0 (
    .clk(clk), .rst(rst), .exp_din(exp_din), .exp_vld(exp_vld), .act_din(act_din),
    .act_vld(act_vld), .flush(flush), .occ(occ[0]), .pass_cnt(pass_cnt[0]),
    .fail_cnt(fail_cnt[0]), .mismatch(mismatch[0]), .overflow(overflow[0]),
    .underflow(underflow[0]), .timeout(timeout[0]), .done(done[0]));

  hd_scoreboard #(.k(8), .DEPTH(DEP), .MAX_LAT(3)) u_sb1 (
    .clk(clk), .rst(rst), .exp_din(exp_din), .exp_vld(exp_vld), .act_din(act_din),
    .act_vld(act_vld), .flush(flush), .occ(occ[1]), .pass_cnt(pass_cnt[1]),
    .fail_cnt(fail_cnt[1]), .mismatch(mismatch[1]), .overflow(overflow[1]),
    .underflow(underflow[1]), .timeout(timeout[1]), .done(done[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      mcnt[i] = 0; mage[i] = 0; m_pass[i] = 0; m_fail[i] = 0;
      m_mis[i] = 0; m_of[i] = 0; m_uf[i] = 0; m_to[i] = 0;
      m_done[i] = 0; m_drain[i] = 0; m_err[i] = 0;
    end
  endtask

  task automatic model_step(input bit ev, input logic [7:0] ed, input bit av,
                            input logic [7:0] ad, input bit fl);
    for (int i = 0; i < 2; i++) begin
      m_mis[i] = 0;
      if (!m_err[i]) begin
        bit was_empty, sticky, accepting, popped, e_uf, e_of, e_to, e_fail;
        was_empty = (mcnt[i] == 0);
        sticky    = m_of[i] | m_uf[i] | m_to[i];
        accepting = !m_drain[i] && !m_done[i];
        popped    = av && !was_empty;
        e_uf      = av && was_empty;
        e_of      = accepting && !fl && ev && (mcnt[i] == DEP) && !popped;
        e_fail    = 0;
        if (popped) begin
          if (mq[i][0] == ad) begin
            if (m_pass[i] < 65535) m_pass[i]++;
          end else begin
            if (m_fail[i] < 65535) m_fail[i]++;
            m_mis[i] = 1; e_fail = 1;
          end
          for (int j = 0; j < DEP - 1; j++) mq[i][j] = mq[i][j+1];
          mcnt[i]--;
        end
        if (accepting && !fl && ev && !e_of) begin
          mq[i][mcnt[i]] = ed;
          mcnt[i]++;
        end
        // Head age: cycles the current oldest entry has waited without a compare.
        if (was_empty || popped)   mage[i] = 0;
        else if (mage[i] < lat[i]) mage[i]++;
        e_to = (mage[i] == lat[i]);
        if (accepting && !was_empty) begin
          if (e_of || e_uf || e_to || (STOP && e_fail) || sticky) m_err[i] = 1;
          else if (fl) m_drain[i] = 1;
        end else if (accepting) begin
          if (fl) m_drain[i] = 1;
        end else if (!m_done[i]) begin
          if (e_uf || e_to || (STOP && e_fail) || sticky) m_err[i] = 1;
          else if (was_empty) m_done[i] = 1;
        end
        m_of[i] |= e_of; m_uf[i] |= e_uf; m_to[i] |= e_to;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("i%0d_occ", i),       32'(occ[i]),       32'(mcnt[i]));
      chk($sformatf("i%0d_pass", i),      32'(pass_cnt[i]),  32'(m_pass[i]));
      chk($sformatf("i%0d_fail", i),      32'(fail_cnt[i]),  32'(m_fail[i]));
      chk($sformatf("i%0d_mismatch", i),  32'(mismatch[i]),  32'(m_mis[i]));
      chk($sformatf("i%0d_overflow", i),  32'(overflow[i]),  32'(m_of[i]));
      chk($sformatf("i%0d_underflow", i), 32'(underflow[i]), 32'(m_uf[i]));
      chk($sformatf("i%0d_timeout", i),   32'(timeout[i]),   32'(m_to[i]));
      chk($sformatf("i%0d_done", i),      32'(done[i]),      32'(m_done[i]));
    end
  endtask

  task automatic step(input bit ev, input logic [7:0] ed, input bit av,
                      input logic [7:0] ad, input bit fl);
    exp_vld = ev; exp_din = ed; act_vld = av; act_din = ad; flush = fl;
    model_step(ev, ed, av, ad, fl);
    @(posedge clk); #1;
    exp_vld = 1'b0; act_vld = 1'b0; flush = 1'b0;
    compare_all();
  endtask

  // Asserted mid-cycle so the outputs must clear without waiting for an edge.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_i%0d_occ", i),  32'(occ[i]), 32'd0);
      chk($sformatf("rst_i%0d_pass", i), 32'(pass_cnt[i]), 32'd0);
      chk($sformatf("rst_i%0d_fail", i), 32'(fail_cnt[i]), 32'd0);
      chk($sformatf("rst_i%0d_flags", i),
          32'({mismatch[i], overflow[i], underflow[i], timeout[i], done[i]}), 32'd0);
    end
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] hd;
    model_clear();
    do_reset();

    // Two matching words, then flush to completion.
    step(1, 8'hA5, 0, 8'h00, 0);
    step(1, 8'h3C, 0, 8'h00, 0);
    step(0, 8'h00, 0, 8'h00, 0);
    step(0, 8'h00, 1, 8'hA5, 0);
    step(0, 8'h00, 1, 8'h3C, 0);
    chk("t1_pass", 32'(pass_cnt[0]), 32'd2);
    chk("t1_fail", 32'(fail_cnt[0]), 32'd0);
    step(0, 8'h00, 0, 8'h00, 1);
    step(0, 8'h00, 0, 8'h00, 1);
    chk("t1_done", 32'(done[0]), 32'd1);
    chk("t1_occ",  32'(occ[0]),  32'd0);

    // Single-bit error, then a clean word.
    do_reset();
    step(1, 8'h11, 0, 8'h00, 0);
    step(0, 8'h00, 1, 8'h10, 0);
    chk("t2_fail", 32'(fail_cnt[0]), 32'd1);
    chk("t2_mis_hi", 32'(mismatch[0]), 32'd1);
    step(0, 8'h00, 0, 8'h00, 0);
    chk("t2_mis_lo", 32'(mismatch[0]), 32'd0);
    step(1, 8'h22, 0, 8'h00, 0);
    step(0, 8'h00, 1, 8'h22, 0);
    chk("t2_pass", 32'(pass_cnt[0]), STOP ? 32'd0 : 32'd1);
    chk("t2_fail_hold", 32'(fail_cnt[0]), 32'd1);

    // Overflow: five pushes into a four-deep queue.
    do_reset();
    for (int j = 0; j < 5; j++) step(1, 8'(j + 1), 0, 8'h00, 0);
    chk("t3_occ", 32'(occ[0]), 32'd4);
    chk("t3_overflow", 32'(overflow[0]), 32'd1);
    step(0, 8'h00, 1, 8'h01, 0);
    chk("t3_pass_frozen", 32'(pass_cnt[0]), 32'd0);
    chk("t3_occ_frozen", 32'(occ[0]), 32'd4);

    // Simultaneous push and pop while full.
    do_reset();
    for (int j = 0; j < 4; j++) step(1, 8'(8'h40 + j), 0, 8'h00, 0);
    for (int j = 0; j < 10; j++)
      step(1, 8'(8'h50 + j), 1, (j < 4) ? 8'(8'h40 + j) : 8'(8'h50 + j - 4), 0);
    chk("t4_occ", 32'(occ[0]), 32'd4);
    chk("t4_pass", 32'(pass_cnt[0]), 32'd10);
    chk("t4_overflow", 32'(overflow[0]), 32'd0);

    // Underflow in IDLE, then head-latency timeout on the MAX_LAT=3 instance.
    do_reset();
    step(0, 8'h00, 1, 8'h77, 0);
    chk("t5_uf0", 32'(underflow[0]), 32'd1);
    chk("t5_uf1", 32'(underflow[1]), 32'd1);
    do_reset();
    step(1, 8'h99, 0, 8'h00, 0);
    step(0, 8'h00, 0, 8'h00, 0);
    step(0, 8'h00, 0, 8'h00, 0);
    chk("t5_to_early", 32'(timeout[1]), 32'd0);
    step(0, 8'h00, 0, 8'h00, 0);
    chk("t5_to_lat3", 32'(timeout[1]), 32'd1);
    chk("t5_to_lat16", 32'(timeout[0]), 32'd0);

    // Reset mid-stream with occ=3 and pass_cnt=5.
    do_reset();
    step(1, 8'h60, 0, 8'h00, 0);
    for (int j = 0; j < 5; j++) step(1, 8'(8'h61 + j), 1, 8'(8'h60 + j), 0);
    step(1, 8'h66, 0, 8'h00, 0);
    step(1, 8'h67, 0, 8'h00, 0);
    chk("t6_occ", 32'(occ[0]), 32'd3);
    chk("t6_pass", 32'(pass_cnt[0]), 32'd5);
    do_reset();
    step(1, 8'h70, 0, 8'h00, 0);
    step(0, 8'h00, 1, 8'h70, 0);
    chk("t6_pass_fresh", 32'(pass_cnt[0]), 32'd1);

    // Randomized traffic with occasional corrupted words, periodic resets.
    for (int n = 0; n < 320; n++) begin
      bit ev, av;
      logic [7:0] ed, ad;
      if (n % 80 == 0) do_reset();
      ev = 1'($urandom_range(0, 1));
      ed = 8'($urandom);
      av = (mcnt[0] > 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      ad = (mcnt[0] > 0) ? mq[0][0] : 8'($urandom);
      if ($urandom_range(0, 7) == 0) ad = ad ^ (8'd1 << $urandom_range(0, 7));
      step(ev, ed, av, ad, 1'b0);
    end
    for (int n = 0; n < 10; n++) begin
      hd = mq[0][0];
      step(0, 8'h00, mcnt[0] > 0, hd, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hd_scoreboard.md
# hd_scoreboard

Parametrised self-checking scoreboard for the Hamming encode/noisy-channel/decode loop. It replaces fixed-latency input delay matching with a FIFO of expected words, so decoders of any latency, including variable latency, can be checked. Each decoder output word is compared against the oldest expected word. The block counts passes and fails, and flags overflow, underflow and latency timeout. It sits in the simulation environment between the data generator (expected side) and the decoder output (actual side).

## Interface
Parameters:
- k, 8, data word width in bits (≥1)
- DEPTH, 16, expected-word FIFO depth (power of two, ≥2)
- MAX_LAT, 32, maximum cycles the head entry may wait for an actual word (≥1)

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- exp_din  in  k  expected word from the generator
- exp_vld  in  1  push exp_din this cycle
- act_din  in  k  decoded word from the DUT
- act_vld  in  1  compare act_din with the FIFO head this cycle
- flush  in  1  level; request drain and end of test
- occ  out  $clog2(DEPTH)+1  FIFO occupancy
- pass_cnt  out  16  matched words, saturating
- fail_cnt  out  16  mismatched words, saturating
- mismatch  out  1  one-cycle pulse per failed compare
- overflow  out  1  sticky; push while full without a pop
- underflow  out  1  sticky; act_vld while FIFO empty
- timeout  out  1  sticky; head waited MAX_LAT cycles
- done  out  1  sticky; drain completed cleanly

## Operation
- FIFO: circular buffer, wr/rd pointers of $clog2(DEPTH)+1 bits, wrap at DEPTH. Full when occ==DEPTH, empty when occ==0.
- Push when exp_vld, state is not ERROR, and (not full, or pop in the same cycle).
- Push when full with no pop: word is dropped and overflow is set.
- Pop on act_vld when FIFO is non-empty. Compare act_din against the head. Equal: pass_cnt++. Otherwise: fail_cnt++ and mismatch pulses. Counters hold at 16'hFFFF.
- act_vld when FIFO is empty: underflow is set, no compare, counters unchanged. A same-cycle push does not bypass; the pushed word is queued.
- Push and pop in the same cycle with FIFO non-empty: occ is unchanged. This includes the full case.
- Age counter, $clog2(MAX_LAT+1) bits:
  - Cleared on pop, and while the FIFO is empty.
  - Otherwise increments each cycle.
  - When it reaches MAX_LAT, timeout is set.
- State machine:
  - IDLE: FIFO empty. Push → RUN. flush → DRAIN.
  - RUN: FIFO non-empty. flush → DRAIN. Underflow, overflow or timeout → ERROR.
  - DRAIN: pushes are ignored. FIFO empty and no sticky error → set done, go to DONE. Timeout or underflow → ERROR.
  - DONE: terminal; only act_vld is still monitored, and it sets underflow.
  - ERROR: terminal. Pushes and compares are ignored and counters freeze. Exit only on rst.
- Priority within one cycle: ERROR transition takes precedence over flush, and flush over push.
- rst mid-operation: pointers, occ, age, counters, sticky flags and state all clear immediately. FIFO contents are not cleared; they are don't-care.

## Timing
- Reset values: occ=0, pass_cnt=0, fail_cnt=0, mismatch=0, overflow=0, underflow=0, timeout=0, done=0, state IDLE.
- All outputs are registered.
- Compare latency is 1 cycle. For act_vld in cycle N, pass_cnt, fail_cnt and mismatch update at edge N+1.
- occ updates at the edge following the push/pop.
- Sticky flags assert at the edge after the cause.
- done asserts at the edge after occ==0 is observed in DRAIN.
- A word pushed at edge N can be compared from cycle N+1 (no same-cycle bypass).

## Configuration
- HD_SB_STOP_ON_FAIL_EN defined: the first mismatch moves RUN/DRAIN → ERROR at the same edge as the fail_cnt increment. fail_cnt then stays at 1.
- Not defined: mismatches only count and pulse mismatch. Checking continues until flush, and done may assert with fail_cnt>0.

## Test plan
- k=8, DEPTH=4. Push 8'hA5, 8'h3C; act 8'hA5, 8'h3C two cycles later → pass_cnt=2, fail_cnt=0. Then flush → done=1, occ=0.
- Push 8'h11; act 8'h10 (1-bit error) → fail_cnt=1 and a one-cycle mismatch pulse. Without the macro, a next push/act of 8'h22 gives pass_cnt=1. With the macro defined: state ERROR, and the later compare leaves pass_cnt=0.
- DEPTH=4. Push 5 words with no act → occ=4, overflow=1, ERROR. Further act_vld leaves counters unchanged.
- Push and pop in the same cycle while full, over 10 cycles of matching data → occ stays 4, pass_cnt=10, overflow=0.
- MAX_LAT=3. Push one word, no act → timeout=1 at the 3rd edge after the push, ERROR. act_vld in IDLE → underflow=1.
- Assert rst for 1 cycle mid-stream (occ=3, pass_cnt=5) → all outputs return to 0 asynchronously. Fresh push/act → pass_cnt=1.
